// File: rtl/dt_fault_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dt_fault_scheduler
// Function : Shares one combinational fault-classifier decision tree among CH
//            feeder channels. Frames are granted round-robin, presented to
//            the classifier from registers, and the captured class feeds a
//            per-channel consecutive-agreement filter that raises sticky
//            trip flags with the confirmed fault class.
// Revision : 1.0 - initial release
// ============================================================================
module dt_fault_scheduler #(
  parameter int N          = 8,
  parameter int C          = 3,
  parameter int CH         = 4,
  parameter int CONFIRM    = 3,
  parameter int NORMAL_CLS = 0,
  parameter int MAX_CLS    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH-1:0]           in_valid,
  output logic [CH-1:0]           in_ready,
  input  logic [CH*N-1:0]         in_va,
  input  logic [CH*N-1:0]         in_vb,
  input  logic [CH*N-1:0]         in_vc,
  input  logic [CH*N-1:0]         in_ia,
  input  logic [CH*N-1:0]         in_ib,
  input  logic [CH*N-1:0]         in_ic,
  output logic [N-1:0]            dt_va,
  output logic [N-1:0]            dt_vb,
  output logic [N-1:0]            dt_vc,
  output logic [N-1:0]            dt_ia,
  output logic [N-1:0]            dt_ib,
  output logic [N-1:0]            dt_ic,
  input  logic [C-1:0]            dt_cls,
  output logic                    res_valid,
  output logic [$clog2(CH)-1:0]   res_ch,
  output logic [C-1:0]            res_cls,
  output logic                    cls_err,
  output logic [CH-1:0]           trip,
  output logic [CH*C-1:0]         trip_cls,
  input  logic [CH-1:0]           trip_ack
);

  localparam int CHW = $clog2(CH);
  localparam int CW  = $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM);
  localparam logic [C-1:0]  NORMAL_C  = C'(NORMAL_CLS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CHW-1:0]   rr_q;
  logic [CHW-1:0]   g_q;
  logic [C-1:0]     cls_q;
  logic [N-1:0]     dt_va_q, dt_vb_q, dt_vc_q, dt_ia_q, dt_ib_q, dt_ic_q;

  logic [C-1:0]     last_q [CH];
  logic [CW-1:0]    cnt_q  [CH];
  logic [CH-1:0]    trip_q;
  logic [C-1:0]     tcls_q [CH];

  logic             w_any_valid;
  logic [CHW-1:0]   w_grant;
  logic [CHW-1:0]   w_next_rr;
  logic             w_fire;
  logic             w_illegal;
  logic [C-1:0]     w_new_last;
  logic [CW-1:0]    w_new_cnt;
  logic             w_set_trip;

  // Per-channel views of the flattened sample buses.
  logic [N-1:0] w_va [CH];
  logic [N-1:0] w_vb [CH];
  logic [N-1:0] w_vc [CH];
  logic [N-1:0] w_ia [CH];
  logic [N-1:0] w_ib [CH];
  logic [N-1:0] w_ic [CH];

  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign w_va[k] = in_va[k*N +: N];
    assign w_vb[k] = in_vb[k*N +: N];
    assign w_vc[k] = in_vc[k*N +: N];
    assign w_ia[k] = in_ia[k*N +: N];
    assign w_ib[k] = in_ib[k*N +: N];
    assign w_ic[k] = in_ic[k*N +: N];
    assign trip_cls[k*C +: C] = tcls_q[k];
  end

  // Round-robin search: first valid channel at or after the pointer, wrapping.
  always_comb begin : p_grant
    int w_idx;
    w_any_valid = 1'b0;
    w_grant     = '0;
    w_idx       = 0;
    for (int i = 0; i < CH; i++) begin
      w_idx = (int'(rr_q) + i) % CH;
      if (!w_any_valid && in_valid[CHW'(w_idx)]) begin
        w_any_valid = 1'b1;
        w_grant     = CHW'(w_idx);
      end
    end
  end

  assign w_next_rr = (w_grant == CHW'(CH - 1)) ? '0 : w_grant + CHW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant; the ready is held low while reset is applied.
  always_comb begin : p_fsm
    state_d  = state_q;
    w_fire   = 1'b0;
    in_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rst_n && w_any_valid) begin
          w_fire            = 1'b1;
          in_ready[w_grant] = 1'b1;
          state_d           = S_EVAL;
        end
      end
      S_EVAL:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture the granted frame, advance the pointer, and register the class.
  always_ff @(posedge clk or negedge rst_n) begin : p_data
    if (!rst_n) begin
      dt_va_q <= '0;
      dt_vb_q <= '0;
      dt_vc_q <= '0;
      dt_ia_q <= '0;
      dt_ib_q <= '0;
      dt_ic_q <= '0;
      g_q     <= '0;
      rr_q    <= '0;
      cls_q   <= '0;
    end else begin
      if (w_fire) begin
        dt_va_q <= w_va[w_grant];
        dt_vb_q <= w_vb[w_grant];
        dt_vc_q <= w_vc[w_grant];
        dt_ia_q <= w_ia[w_grant];
        dt_ib_q <= w_ib[w_grant];
        dt_ic_q <= w_ic[w_grant];
        g_q     <= w_grant;
        rr_q    <= w_next_rr;
      end
      if (state_q == S_EVAL) begin
        cls_q <= dt_cls;
      end
    end
  end

  assign dt_va     = dt_va_q;
  assign dt_vb     = dt_vb_q;
  assign dt_vc     = dt_vc_q;
  assign dt_ia     = dt_ia_q;
  assign dt_ib     = dt_ib_q;
  assign dt_ic     = dt_ic_q;
  assign res_valid = (state_q == S_UPDATE);
  assign res_ch    = g_q;
  assign res_cls   = cls_q;
  assign w_illegal = (int'(cls_q) > MAX_CLS);
  assign cls_err   = res_valid && w_illegal;

  // Filter step for the channel whose result is being reported.
  always_comb begin : p_filter
    w_new_last = last_q[g_q];
    w_new_cnt  = cnt_q[g_q];
    if (w_illegal) begin
      w_new_cnt = '0;
    end else if (cls_q == last_q[g_q]) begin
      // Saturate so a persisting fault keeps re-tripping after an ack.
      w_new_cnt = (cnt_q[g_q] == CONFIRM_C) ? cnt_q[g_q] : cnt_q[g_q] + CW'(1);
    end else begin
      w_new_last = cls_q;
      w_new_cnt  = CW'(1);
    end
    w_set_trip = res_valid && !w_illegal && (w_new_cnt == CONFIRM_C) &&
                 (cls_q != NORMAL_C) && !trip_q[g_q];
  end

  // Filter state and sticky trips; a set beats a coincident ack.
  always_ff @(posedge clk or negedge rst_n) begin : p_trip
    if (!rst_n) begin
      trip_q <= '0;
      for (int k = 0; k < CH; k++) begin
        last_q[k] <= NORMAL_C;
        cnt_q[k]  <= '0;
        tcls_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (res_valid && (g_q == CHW'(k))) begin
          last_q[k] <= w_new_last;
          cnt_q[k]  <= w_new_cnt;
        end
        if (w_set_trip && (g_q == CHW'(k))) begin
          trip_q[k] <= 1'b1;
          tcls_q[k] <= cls_q;
        end else if (trip_ack[k]) begin
          trip_q[k] <= 1'b0;
          tcls_q[k] <= '0;
        end
      end
    end
  end

  assign trip = trip_q;

endmodule
`default_nettype wire
